// File: rtl/shift_word_receiver_if.sv
// Parallel word handshake between the serial receiver and its consumer.
// The receiver uses the master modport and the consumer uses the slave modport.
interface shift_word_receiver_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;

  modport master (
    output q,
    output q_valid,
    input  q_ready
  );

  modport slave (
    input  q,
    input  q_valid,
    output q_ready
  );
endinterface

// File: rtl/shift_word_receiver.sv
// Serial-in/parallel-out frame receiver (start, WIDTH data, [parity], stop) with a one-entry output buffer.
// Define PARITY_CHECK_EN to add even-parity checking and the parity_err output.
module shift_word_receiver #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 CR,
  input  logic                 bit_en,
  input  logic                 sdi,
  input  logic                 dir,
  shift_word_receiver_if.master bus,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 err_clr
`ifdef PARITY_CHECK_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
`ifdef PARITY_CHECK_EN
    PARITY = 2'd2,
`endif
    STOP   = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sh_reg, sh_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             dir_reg, dir_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             q_valid_reg, q_valid_next;
  logic             frame_err_reg, frame_err_next;
  logic             overrun_reg, overrun_next;
  logic             word_done;
  logic             overrun_evt;
`ifdef PARITY_CHECK_EN
  logic             parity_err_reg, parity_err_next;
  logic             drop_reg, drop_next;
`endif

  // Both candidate shift results, one per direction, built bit by bit.
  logic [WIDTH-1:0] sh_lsb, sh_msb;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_lsb_top
        assign sh_lsb[gi] = sdi;
      end else begin : g_lsb_mid
        assign sh_lsb[gi] = sh_reg[gi+1];
      end
      if (gi == 0) begin : g_msb_bot
        assign sh_msb[gi] = sdi;
      end else begin : g_msb_mid
        assign sh_msb[gi] = sh_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    sh_next        = sh_reg;
    cnt_next       = cnt_reg;
    dir_next       = dir_reg;
    q_next         = q_reg;
    q_valid_next   = q_valid_reg;
    frame_err_next = 1'b0;
    overrun_next   = overrun_reg;
    word_done      = 1'b0;
    overrun_evt    = 1'b0;
`ifdef PARITY_CHECK_EN
    parity_err_next = 1'b0;
    drop_next       = drop_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (bit_en && !sdi) begin
          state_next = DATA;
          dir_next   = dir;
          cnt_next   = '0;
`ifdef PARITY_CHECK_EN
          drop_next  = 1'b0;
`endif
        end
      end
      DATA: begin
        if (bit_en) begin
          sh_next = dir_reg ? sh_msb : sh_lsb;
          if (cnt_reg == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        // Data plus parity bit must hold an even number of ones.
        if (bit_en) begin
          if ((^sh_reg) ^ sdi) begin
            parity_err_next = 1'b1;
            drop_next       = 1'b1;
          end
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_en) begin
          state_next = IDLE;
          if (sdi) begin
`ifdef PARITY_CHECK_EN
            word_done = !drop_reg;
`else
            word_done = 1'b1;
`endif
          end else begin
            frame_err_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A consumer taking the old word makes room for the new one on the same edge.
    if (word_done) begin
      if (!q_valid_reg || bus.q_ready) begin
        q_next       = sh_reg;
        q_valid_next = 1'b1;
      end else begin
        overrun_evt = 1'b1;
      end
    end else if (q_valid_reg && bus.q_ready) begin
      q_valid_next = 1'b0;
    end

    if (overrun_evt) begin
      overrun_next = 1'b1;
    end else if (err_clr) begin
      overrun_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge CR) begin
    if (CR) begin
      state_reg     <= IDLE;
      sh_reg        <= '0;
      cnt_reg       <= '0;
      dir_reg       <= 1'b0;
      q_reg         <= '0;
      q_valid_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err_reg <= 1'b0;
      drop_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      sh_reg        <= sh_next;
      cnt_reg       <= cnt_next;
      dir_reg       <= dir_next;
      q_reg         <= q_next;
      q_valid_reg   <= q_valid_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
`ifdef PARITY_CHECK_EN
      parity_err_reg <= parity_err_next;
      drop_reg       <= drop_next;
`endif
    end
  end

  assign bus.q       = q_reg;
  assign bus.q_valid = q_valid_reg;
  assign busy        = (state_reg != IDLE);
  assign frame_err   = frame_err_reg;
  assign overrun     = overrun_reg;
`ifdef PARITY_CHECK_EN
  assign parity_err  = parity_err_reg;
`endif

endmodule
